stage_if: RTL and testbench
===========================

# stage_if

Instruction-fetch stage of the RV32I pipeline, directly upstream of the decode stage. It owns the program counter and issues word reads to instruction memory over a request/ready handshake. It holds the fetched word and its address in the IF/ID output register, and absorbs decode-stage stalls with a one-entry skid buffer. Branch/jump redirects computed in decode flush the fetch path, including a read that is already in flight.

## Interface
Parameters:
- PC_WIDTH, 32, width of program counter and instruction address
- ADDR_WIDTH, 32, width of memory address bus (PC zero-extended or truncated)
- RESET_PC, 0, PC value after reset
- NOP_INST, 32'h00000013, instruction word presented while o_Valid=0 (addi x0,x0,0)

Ports:
- i_Clock  in  1  clock; single clock domain
- i_Reset  in  1  reset; synchronous, active-high
- i_Stall  in  1  decode cannot accept; hold output register
- i_Redirect  in  1  decode resolved a taken branch/jump this cycle
- i_RedirectPC  in  PC_WIDTH  redirect target; bits [1:0] ignored
- o_MemAddr  out  ADDR_WIDTH  read address
- o_MemRdEnable  out  1  read request
- i_MemReady  in  1  request completes this cycle; i_MemData valid
- i_MemData  in  32  instruction word
- o_Inst  out  32  instruction to decode
- o_PC  out  PC_WIDTH  address of o_Inst
- o_Valid  out  1  o_Inst/o_PC hold a real instruction

## Operation
- Registers: PC, output register OR (o_Valid, o_Inst, o_PC), skid buffer SB (inst, pc), DRAIN target TGT, state.
- OR is consumed in any cycle with o_Valid=1 and i_Stall=0.
- OR is free if o_Valid=0 or it is consumed this cycle.
- Request rule: once o_MemRdEnable=1, o_MemAddr stays stable until i_MemReady=1.
- PC arithmetic: PC+4 modulo 2^PC_WIDTH, with wrap at all-ones.
- PC[1:0] is always 0, and the redirect target is loaded as {i_RedirectPC[PC_WIDTH-1:2],2'b00}.
- Redirect has priority over stall. Decode only asserts i_Redirect when it is not stalled.
- A redirect always loads a bubble into OR: o_Valid=0, o_Inst=NOP_INST. OR is flushed because its pending content is the wrong-path successor.
- FETCH state: o_MemRdEnable=1, o_MemAddr=PC.
  - i_Redirect and i_MemReady: discard the data, PC<=target, stay in FETCH.
  - i_Redirect and !i_MemReady: TGT<=target, go to DRAIN.
  - i_MemReady and OR free: OR<={1,i_MemData,PC}, PC<=PC+4.
  - i_MemReady and OR not free: SB<={i_MemData,PC}, PC<=PC+4, go to HOLD.
  - No completion but OR consumed: o_Valid<=0.
- HOLD state: o_MemRdEnable=0.
  - i_Redirect: clear SB, PC<=target, go to FETCH.
  - Else, if !i_Stall: OR<=SB, go to FETCH.
- DRAIN state: o_MemRdEnable=1, o_MemAddr=old PC, o_Valid=0.
  - A new i_Redirect overwrites TGT.
  - i_MemReady: discard the data, PC<=TGT (or the new target if a redirect arrives in the same cycle), go to FETCH.
- Reset (any state, including mid-request):
  - State=FETCH, PC=RESET_PC, o_Valid=0, o_Inst=NOP_INST, o_PC=RESET_PC, SB cleared.
  - o_MemRdEnable is forced to 0 while i_Reset=1, and an abandoned read is not resumed.
- Idle output: o_MemAddr tracks PC in every state.

## Timing
- Zero-wait memory (i_MemReady same cycle as request): fetch-to-output latency is 1 cycle, and throughput is 1 instruction/cycle.
- First request is issued in the cycle after reset deasserts, at RESET_PC. With zero-wait memory o_Valid=1 the following cycle.
- Redirect in cycle t from FETCH with ready: o_MemAddr=target at t+1, and the first valid target instruction appears at t+2.
- Redirect in cycle t with a read pending: the wrong-path read drains, and the target is requested in the cycle after i_MemReady.
- Stall with HOLD: SB drains to OR in the first cycle with i_Stall=0. The next request is issued in that same cycle's successor state, so no instruction is lost or duplicated.
- N wait states per fetch: throughput is 1/(N+1).

## Test plan
- Reset then zero-wait memory returning PC as data: o_PC and o_Inst sequence 0,4,8,C with o_Valid=1 from the 2nd cycle after reset.
- i_Stall held for 3 cycles while o_PC=8 and a read of C completes: o_PC stays 8. Then C and 10 follow consecutively with no gap or duplicate, and o_MemRdEnable=0 during HOLD.
- i_Redirect=1 with i_RedirectPC=0x103, 2 wait states: the pending read drains, the next request is 0x100, o_Valid=0 until 0x100 is delivered, and the wrong-path data never appears on o_Inst.
- Redirect to 0x200 during DRAIN, followed by a second redirect to 0x300 before ready: the first new request is 0x300.
- PC_WIDTH=32 starting at RESET_PC=0xFFFFFFF8: o_PC sequence FFFFFFF8, FFFFFFFC, 0.
- Assert reset mid-wait-state: o_MemRdEnable=0 during reset, o_Valid=0, o_Inst=0x00000013, and the fetch restarts at RESET_PC.

Source files
------------

// File: rtl/stage_if.sv
// RV32I instruction-fetch stage: owns the PC, issues word reads over a
// request/ready handshake, and feeds decode through an output register with a one-entry skid buffer.
module stage_if #(
  parameter int                   PC_WIDTH   = 32,
  parameter int                   ADDR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]  RESET_PC   = '0,
  parameter logic [31:0]          NOP_INST   = 32'h00000013
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset,
  input  logic                  i_Stall,
  input  logic                  i_Redirect,
  input  logic [PC_WIDTH-1:0]   i_RedirectPC,
  output logic [ADDR_WIDTH-1:0] o_MemAddr,
  output logic                  o_MemRdEnable,
  input  logic                  i_MemReady,
  input  logic [31:0]           i_MemData,
  output logic [31:0]           o_Inst,
  output logic [PC_WIDTH-1:0]   o_PC,
  output logic                  o_Valid
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [PC_WIDTH-1:0] RESET_PC_ALIGNED = {RESET_PC[PC_WIDTH-1:2], 2'b00};

  state_t               state_reg, state_next;
  logic [PC_WIDTH-1:0]  pc_reg, pc_next;
  logic [PC_WIDTH-1:0]  tgt_reg, tgt_next;
  logic                 out_valid_reg, out_valid_next;
  logic [31:0]          out_inst_reg, out_inst_next;
  logic [PC_WIDTH-1:0]  out_pc_reg, out_pc_next;
  logic [31:0]          sb_inst_reg, sb_inst_next;
  logic [PC_WIDTH-1:0]  sb_pc_reg, sb_pc_next;

  logic [PC_WIDTH-1:0]  redirect_target;
  logic [PC_WIDTH-1:0]  pc_inc;
  logic                 or_consumed;
  logic                 or_free;
  logic                 unused_redirect_low;

  assign redirect_target     = {i_RedirectPC[PC_WIDTH-1:2], 2'b00};
  assign unused_redirect_low = ^i_RedirectPC[1:0];
  assign pc_inc              = pc_reg + PC_WIDTH'(4);
  assign or_consumed         = out_valid_reg && !i_Stall;
  assign or_free             = !out_valid_reg || or_consumed;

  // HOLD is the only state without a request; reset kills any request outright.
  assign o_MemRdEnable = !i_Reset && (state_reg != HOLD);

  generate
    if (ADDR_WIDTH > PC_WIDTH) begin : g_addr_ext
      assign o_MemAddr = {{(ADDR_WIDTH-PC_WIDTH){1'b0}}, pc_reg};
    end else if (ADDR_WIDTH == PC_WIDTH) begin : g_addr_eq
      assign o_MemAddr = pc_reg;
    end else begin : g_addr_trunc
      assign o_MemAddr = pc_reg[ADDR_WIDTH-1:0];
    end
  endgenerate

  assign o_Valid = out_valid_reg;
  assign o_Inst  = out_inst_reg;
  assign o_PC    = out_pc_reg;

  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    tgt_next       = tgt_reg;
    out_valid_next = out_valid_reg;
    out_inst_next  = out_inst_reg;
    out_pc_next    = out_pc_reg;
    sb_inst_next   = sb_inst_reg;
    sb_pc_next     = sb_pc_reg;

    case (state_reg)
      FETCH: begin
        if (i_Redirect) begin
          out_valid_next = 1'b0;
          out_inst_next  = NOP_INST;
          if (i_MemReady) begin
            pc_next = redirect_target;
          end else begin
            // The read in flight must finish at its current address first.
            tgt_next   = redirect_target;
            state_next = DRAIN;
          end
        end else if (i_MemReady) begin
          pc_next = pc_inc;
          if (or_free) begin
            out_valid_next = 1'b1;
            out_inst_next  = i_MemData;
            out_pc_next    = pc_reg;
          end else begin
            sb_inst_next = i_MemData;
            sb_pc_next   = pc_reg;
            state_next   = HOLD;
          end
        end else if (or_consumed) begin
          out_valid_next = 1'b0;
          out_inst_next  = NOP_INST;
        end
      end

      HOLD: begin
        if (i_Redirect) begin
          sb_inst_next   = NOP_INST;
          sb_pc_next     = '0;
          pc_next        = redirect_target;
          out_valid_next = 1'b0;
          out_inst_next  = NOP_INST;
          state_next     = FETCH;
        end else if (!i_Stall) begin
          out_valid_next = 1'b1;
          out_inst_next  = sb_inst_reg;
          out_pc_next    = sb_pc_reg;
          state_next     = FETCH;
        end
      end

      DRAIN: begin
        out_valid_next = 1'b0;
        out_inst_next  = NOP_INST;
        if (i_Redirect) begin
          tgt_next = redirect_target;
        end
        if (i_MemReady) begin
          pc_next    = i_Redirect ? redirect_target : tgt_reg;
          state_next = FETCH;
        end
      end

      default: begin
        state_next = FETCH;
      end
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_reg     <= FETCH;
      pc_reg        <= RESET_PC_ALIGNED;
      tgt_reg       <= '0;
      out_valid_reg <= 1'b0;
      out_inst_reg  <= NOP_INST;
      out_pc_reg    <= RESET_PC_ALIGNED;
      sb_inst_reg   <= NOP_INST;
      sb_pc_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      pc_reg        <= pc_next;
      tgt_reg       <= tgt_next;
      out_valid_reg <= out_valid_next;
      out_inst_reg  <= out_inst_next;
      out_pc_reg    <= out_pc_next;
      sb_inst_reg   <= sb_inst_next;
      sb_pc_reg     <= sb_pc_next;
    end
  end

endmodule

// File: tb/tb_stage_if.sv
// Bench for stage_if: a cycle table of directed corner cases, then random
// stall/redirect/wait-state traffic checked against a program-order PC model.
module tb_stage_if;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] mem_addr;
  logic        mem_rd;
  logic        mem_ready;
  logic [31:0] mem_data;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        valid;

  // Second instance: zero-wait memory, never stalled, starting near the top of the address space.
  logic        w_stall;
  logic        w_redirect;
  logic [31:0] w_redirect_pc;
  logic [31:0] w_addr;
  logic        w_rd;
  logic        w_ready;
  logic [31:0] w_data;
  logic [31:0] w_inst;
  logic [31:0] w_pc;
  logic        w_valid;

  int checks;
  int errors;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return {a[15:0] ^ 16'h1357, ~a[15:0]};
  endfunction

  assign w_stall       = 1'b0;
  assign w_redirect    = 1'b0;
  assign w_redirect_pc = '0;
  assign w_ready       = w_rd;
  assign w_data        = data_of(w_addr);

  stage_if dut (
    .i_Clock(clk), .i_Reset(reset), .i_Stall(stall), .i_Redirect(redirect),
    .i_RedirectPC(redirect_pc), .o_MemAddr(mem_addr), .o_MemRdEnable(mem_rd),
    .i_MemReady(mem_ready), .i_MemData(mem_data), .o_Inst(inst), .o_PC(pc), .o_Valid(valid)
  );

  stage_if #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .i_Clock(clk), .i_Reset(reset), .i_Stall(w_stall), .i_Redirect(w_redirect),
    .i_RedirectPC(w_redirect_pc), .o_MemAddr(w_addr), .o_MemRdEnable(w_rd),
    .i_MemReady(w_ready), .i_MemData(w_data), .o_Inst(w_inst), .o_PC(w_pc), .o_Valid(w_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        stl;
    logic        rdr;
    logic [31:0] rpc;
    logic        rdy;
    logic        exp_rd;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic        chk_pc;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vq[$];

  task automatic row(input logic rst, input logic stl, input logic rdr, input logic [31:0] rpc,
                     input logic rdy, input logic erd, input logic [31:0] eaddr,
                     input logic evalid, input logic cpc, input logic [31:0] epc);
    vec_t v;
    v.rst = rst; v.stl = stl; v.rdr = rdr; v.rpc = rpc; v.rdy = rdy;
    v.exp_rd = erd; v.exp_addr = eaddr; v.exp_valid = evalid; v.chk_pc = cpc; v.exp_pc = epc;
    vq.push_back(v);
  endtask

  logic [31:0] exp_pc;
  logic [31:0] exp_wpc;
  int          consumed;
  logic        prev_pending, prev_hold;
  logic [31:0] prev_addr, prev_pc, prev_inst;
  logic        r_reset, r_stall, r_redir;
  logic [31:0] r_rpc;

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    mem_ready = 1'b0; mem_data = '0;

    //   rst stl rdr rpc      rdy | rd  addr      valid chkpc pc
    row(1, 0, 0, 32'h0,   0,   0, 32'h000, 0, 1, 32'h000); // reset state
    row(1, 0, 0, 32'h0,   0,   0, 32'h000, 0, 1, 32'h000);
    row(0, 0, 0, 32'h0,   1,   1, 32'h000, 0, 1, 32'h000); // first request at RESET_PC
    row(0, 0, 0, 32'h0,   1,   1, 32'h004, 1, 1, 32'h000);
    row(0, 0, 0, 32'h0,   1,   1, 32'h008, 1, 1, 32'h004);
    row(0, 1, 0, 32'h0,   1,   1, 32'h00C, 1, 1, 32'h008); // C lands in skid buffer
    row(0, 1, 0, 32'h0,   0,   0, 32'h010, 1, 1, 32'h008);
    row(0, 1, 0, 32'h0,   0,   0, 32'h010, 1, 1, 32'h008);
    row(0, 0, 0, 32'h0,   0,   0, 32'h010, 1, 1, 32'h008);
    row(0, 0, 0, 32'h0,   1,   1, 32'h010, 1, 1, 32'h00C);
    row(0, 0, 1, 32'h103, 0,   1, 32'h014, 1, 1, 32'h010); // redirect with read pending
    row(0, 0, 0, 32'h0,   0,   1, 32'h014, 0, 0, 32'h000);
    row(0, 0, 0, 32'h0,   1,   1, 32'h014, 0, 0, 32'h000);
    row(0, 0, 0, 32'h0,   1,   1, 32'h100, 0, 0, 32'h000);
    row(0, 0, 0, 32'h0,   0,   1, 32'h104, 1, 1, 32'h100);
    row(0, 0, 1, 32'h200, 0,   1, 32'h104, 0, 0, 32'h000); // redirect, then re-redirect in DRAIN
    row(0, 0, 1, 32'h302, 0,   1, 32'h104, 0, 0, 32'h000);
    row(0, 0, 0, 32'h0,   1,   1, 32'h104, 0, 0, 32'h000);
    row(0, 0, 0, 32'h0,   1,   1, 32'h300, 0, 0, 32'h000);
    row(0, 0, 0, 32'h0,   0,   1, 32'h304, 1, 1, 32'h300);
    row(0, 0, 1, 32'h040, 1,   1, 32'h304, 0, 0, 32'h000); // redirect with ready
    row(0, 0, 0, 32'h0,   1,   1, 32'h040, 0, 0, 32'h000);
    row(0, 0, 0, 32'h0,   0,   1, 32'h044, 1, 1, 32'h040);
    row(1, 0, 0, 32'h0,   0,   0, 32'h044, 0, 0, 32'h000); // reset mid-wait
    row(0, 0, 0, 32'h0,   1,   1, 32'h000, 0, 1, 32'h000);
    row(0, 1, 0, 32'h0,   1,   1, 32'h004, 1, 1, 32'h000);
    row(0, 0, 1, 32'h080, 0,   0, 32'h008, 1, 1, 32'h000); // redirect out of HOLD
    row(0, 0, 0, 32'h0,   1,   1, 32'h080, 0, 0, 32'h000);
    row(0, 0, 0, 32'h0,   0,   1, 32'h084, 1, 1, 32'h080);

    for (int k = 0; k < vq.size(); k++) begin
      @(negedge clk);
      reset = vq[k].rst; stall = vq[k].stl; redirect = vq[k].rdr; redirect_pc = vq[k].rpc;
      #1;
      mem_ready = vq[k].rdy;
      mem_data  = vq[k].rdy ? data_of(mem_addr) : $urandom;
      #1;
      $display("row %0d: rd=%b addr=%h valid=%b pc=%h inst=%h", k, mem_rd, mem_addr, valid, pc, inst);
      check($sformatf("row%0d_rd", k), {31'b0, mem_rd}, {31'b0, vq[k].exp_rd});
      check($sformatf("row%0d_addr", k), mem_addr, vq[k].exp_addr);
      check($sformatf("row%0d_valid", k), {31'b0, valid}, {31'b0, vq[k].exp_valid});
      check($sformatf("row%0d_inst", k), inst, vq[k].exp_valid ? data_of(vq[k].exp_pc) : NOP);
      if (vq[k].chk_pc) check($sformatf("row%0d_pc", k), pc, vq[k].exp_pc);
      if (k <= 6) begin
        exp_wpc = (k >= 3) ? 32'hFFFF_FFF8 + 32'(4 * (k - 3)) : 32'hFFFF_FFF8;
        check($sformatf("wrap%0d_valid", k), {31'b0, w_valid}, {31'b0, k >= 3});
        check($sformatf("wrap%0d_pc", k), w_pc, exp_wpc);
        if (k >= 3) check($sformatf("wrap%0d_inst", k), w_inst, data_of(exp_wpc));
      end
    end

    // Random phase: decode consumes instructions in program order from RESET_PC,
    // stepping by 4 and jumping to each (aligned) redirect target.
    @(negedge clk);
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    exp_pc = 32'h0;
    consumed = 0;
    prev_pending = 1'b0; prev_hold = 1'b0;
    prev_addr = '0; prev_pc = '0; prev_inst = '0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      r_reset = ($urandom_range(0, 199) == 0);
      r_stall = ($urandom_range(0, 3) == 0);
      r_redir = !r_reset && !r_stall && ($urandom_range(0, 9) == 0);
      r_rpc   = $urandom & 32'h0000_3FFF;
      reset = r_reset; stall = r_stall; redirect = r_redir; redirect_pc = r_rpc;
      #1;
      mem_ready = mem_rd && ($urandom_range(0, 2) != 0);
      mem_data  = mem_ready ? data_of(mem_addr) : $urandom;
      #1;
      if (prev_pending) begin
        check("req_addr_stable", mem_addr, prev_addr);
        if (!r_reset) check("req_held", {31'b0, mem_rd}, 32'd1);
      end
      if (r_reset) check("rd_in_reset", {31'b0, mem_rd}, 32'd0);
      if (!valid) check("bubble_nop", inst, NOP);
      if (prev_hold) begin
        check("stall_valid", {31'b0, valid}, 32'd1);
        check("stall_pc", pc, prev_pc);
        check("stall_inst", inst, prev_inst);
      end
      if (valid && !r_stall && !r_redir && !r_reset) begin
        check("stream_pc", pc, exp_pc);
        check("stream_inst", inst, data_of(exp_pc));
        exp_pc = exp_pc + 32'd4;
        consumed++;
      end
      if (r_redir) exp_pc = r_rpc & 32'hFFFF_FFFC;
      if (r_reset) exp_pc = 32'h0;
      prev_pending = mem_rd && !mem_ready && !r_reset;
      prev_addr    = mem_addr;
      prev_hold    = valid && r_stall && !r_redir && !r_reset;
      prev_pc      = pc;
      prev_inst    = inst;
    end
    check("progress", {31'b0, consumed > 300}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
